// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_arb_pkg
//  Description : Shared constants, state type and helpers for the register
//                write arbiter (reg_write_arbiter + rr_pick).
//                Default requester count, data width and burst limit live
//                here so the top and the bench agree on them.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_arb_pkg;

  localparam int DEF_NUM_REQ   = 3;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MAX_BURST = 4;

  // IDLE   : no grant this cycle
  // GRANT  : single unlocked grant
  // LOCKED : burst in progress, owner holds the port
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // One-hot to index. Input is a zero-extended one-hot vector of at most
  // 32 requesters; an all-zero vector maps to 0.
  function automatic int oh2idx(input logic [31:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating-priority picker. Scans req starting
//                at index ptr and wrapping modulo NUM_REQ; the first set bit
//                wins.
//  Ports       : req    [NUM_REQ-1:0] in  - request vector
//                ptr    [PTR_W-1:0]   in  - highest-priority index (< NUM_REQ)
//                winner [NUM_REQ-1:0] out - one-hot winner (zero if none)
//                valid                out - at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  always_comb begin
    int         w_pos;
    logic [PTR_W-1:0] w_sel;
    winner = '0;
    valid  = 1'b0;
    w_pos  = 0;
    w_sel  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr is always below NUM_REQ, so one subtraction completes the wrap
      w_pos = int'(ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      w_sel = PTR_W'(w_pos);
      if (!valid && req[w_sel]) begin
        winner[w_sel] = 1'b1;
        valid         = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Arbitrates NUM_REQ requesters onto one shared register write
//                port. Round-robin between unlocked requests; a locked winner
//                keeps the port for up to MAX_BURST consecutive grants.
//                gnt and D are registered (1-cycle req->gnt latency);
//                load_en is the OR of the registered grant.
//  Ports       : clk                       in  - clock, rising edge
//                reset                     in  - async reset, active low
//                req   [NUM_REQ-1:0]       in  - request per requester
//                lock  [NUM_REQ-1:0]       in  - burst hold per requester
//                wdata [NUM_REQ*DATA_W-1:0] in - requester i at [i*DATA_W +: DATA_W]
//                gnt   [NUM_REQ-1:0]       out - one-hot-or-zero grant
//                load_en                   out - shared register load enable
//                D     [DATA_W-1:0]        out - shared register data input
//  Revision    : 1.0  initial release
// ============================================================================
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,   // 2..32
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      load_en,
  output logic [DATA_W-1:0]         D
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_e           r_state;
  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     r_owner;
  logic [BURST_W-1:0]   r_burst;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [DATA_W-1:0]    r_d;

  arb_state_e           w_state_nxt;
  logic [PTR_W-1:0]     w_ptr_nxt;
  logic [PTR_W-1:0]     w_owner_nxt;
  logic [BURST_W-1:0]   w_burst_nxt;
  logic [NUM_REQ-1:0]   w_gnt_nxt;
  logic [DATA_W-1:0]    w_d_nxt;

  logic [NUM_REQ-1:0]   w_win;
  logic                 w_valid;
  logic [PTR_W-1:0]     w_win_idx;
  logic                 w_hold;

  // Index following i, modulo NUM_REQ
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_win),
    .valid  (w_valid)
  );

  assign w_win_idx = PTR_W'(oh2idx(32'(w_win)));

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = IDLE;
    w_gnt_nxt   = '0;
    w_d_nxt     = r_d;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_burst_nxt = '0;

    // The owner keeps the port only while it still asks, still locks, and has
    // burst budget left; otherwise fall through to plain round-robin. Since
    // ptr already sits at owner+1, the release arbitration starts there.
    w_hold = (r_state == LOCKED) && req[r_owner] && lock[r_owner] &&
             (r_burst < BURST_W'(MAX_BURST));

    if (w_hold) begin
      w_state_nxt        = LOCKED;
      w_gnt_nxt[r_owner] = 1'b1;
      w_d_nxt            = wdata[r_owner*DATA_W +: DATA_W];
      w_ptr_nxt          = ptr_inc(r_owner);
      w_burst_nxt        = r_burst + BURST_W'(1);
    end else if (w_valid) begin
      w_gnt_nxt = w_win;
      w_d_nxt   = wdata[w_win_idx*DATA_W +: DATA_W];
      w_ptr_nxt = ptr_inc(w_win_idx);
      if (lock[w_win_idx]) begin
        w_state_nxt = LOCKED;
        w_owner_nxt = w_win_idx;
        w_burst_nxt = BURST_W'(1);
      end else begin
        w_state_nxt = GRANT;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_burst <= '0;
      r_gnt   <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_burst <= w_burst_nxt;
      r_gnt   <= w_gnt_nxt;
      r_d     <= w_d_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign load_en = |r_gnt;
  assign D       = r_d;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_arbiter
//  Description : Directed self-checking bench for reg_write_arbiter with a
//                model of the shared register fed by load_en/D.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_write_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 16;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic                      load_en;
  logic [DATA_W-1:0]         D;

  logic [DATA_W-1:0]         r_q;

  int n_vec;
  int n_err;

  reg_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .lock    (lock),
    .wdata   (wdata),
    .gnt     (gnt),
    .load_en (load_en),
    .D       (D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared register being written
  always @(posedge clk) begin
    if (load_en) r_q <= D;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // check grant, load enable and data after one edge
  task automatic step_chk(input string tag, input logic [2:0] g, input logic [15:0] d);
    step();
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".load_en"}, 32'(load_en), 32'(|g));
    chk({tag, ".D"}, 32'(D), 32'(d));
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    req   = 3'b111;
    lock  = 3'b000;
    wdata = {16'h3333, 16'h2222, 16'h1111};

    // Reset held with all requests pending
    step();
    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.load_en", 32'(load_en), 32'h0);
    chk("rst.D", 32'(D), 32'h0);
    step();
    chk("rst2.gnt", 32'(gnt), 32'h0);

    // Fairness from reset
    reset = 1'b1;
    step_chk("rr0", 3'b001, 16'h1111);
    step_chk("rr1", 3'b010, 16'h2222);
    step_chk("rr2", 3'b100, 16'h3333);
    step_chk("rr3", 3'b001, 16'h1111);   // ptr now 1

    // Single write, then shared register one edge later
    req   = 3'b010;
    wdata = {16'h3333, 16'hBEEF, 16'h1111};
    step_chk("single", 3'b010, 16'hBEEF);
    req = 3'b000;
    step_chk("single_idle", 3'b000, 16'hBEEF);
    chk("single.Q", 32'(r_q), 32'hBEEF);

    // Idle hold after a 0x1234 write (ptr is 2, only req0 asks)
    req   = 3'b001;
    wdata = {16'h3333, 16'h2222, 16'h1234};
    step_chk("w1234", 3'b001, 16'h1234);
    req = 3'b000;
    step_chk("idle0", 3'b000, 16'h1234);
    step_chk("idle1", 3'b000, 16'h1234);

    // Burst from ptr=0: 4 locked grants, then requester 1, then 0 again
    do_reset();
    chk("rst_pulse.D", 32'(D), 32'h0);
    req   = 3'b011;
    lock  = 3'b001;
    wdata = {16'h3333, 16'h2222, 16'hA5A5};
    step_chk("burst0", 3'b001, 16'hA5A5);
    step_chk("burst1", 3'b001, 16'hA5A5);
    step_chk("burst2", 3'b001, 16'hA5A5);
    step_chk("burst3", 3'b001, 16'hA5A5);
    step_chk("burst_rel", 3'b010, 16'h2222);
    step_chk("burst_again", 3'b001, 16'hA5A5);

    // Lock drop inside a burst hands the port on round-robin
    do_reset();
    step_chk("drop0", 3'b001, 16'hA5A5);
    lock = 3'b000;
    step_chk("drop1", 3'b010, 16'h2222);

    // Reset mid-burst clears outputs without waiting for an edge
    do_reset();
    lock = 3'b001;
    step_chk("mid0", 3'b001, 16'hA5A5);
    step_chk("mid1", 3'b001, 16'hA5A5);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst.gnt", 32'(gnt), 32'h0);
    chk("mid_rst.load_en", 32'(load_en), 32'h0);
    chk("mid_rst.D", 32'(D), 32'h0);
    #1;
    reset = 1'b1;
    req   = 3'b111;
    lock  = 3'b000;
    step_chk("post_rst", 3'b001, 16'hA5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
